// File: rtl/gps_corr_accum.sv
// GPS single-channel correlator: carrier wipe-off, early/prompt/late code mixing, 1 ms accumulate-and-dump.
// Optional macro CORR_SAT_EN: saturating accumulators plus a sticky acc_ovf flag (otherwise the sums wrap and acc_ovf stays 0).
module gps_corr_accum #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
) (
  input  logic                    mclk,
  input  logic                    mclr,
  input  logic                    enable,
  input  logic                    if_valid,
  input  logic                    if_sign,
  input  logic                    if_mag,
  input  logic [2:0]              nco_carrier_cos,
  input  logic [2:0]              nco_carrier_sin,
  input  logic                    code_early,
  input  logic                    code_prompt,
  input  logic                    code_late,
  input  logic                    dump_strobe,
  output logic signed [ACC_W-1:0] i_e,
  output logic signed [ACC_W-1:0] q_e,
  output logic signed [ACC_W-1:0] i_p,
  output logic signed [ACC_W-1:0] q_p,
  output logic signed [ACC_W-1:0] i_l,
  output logic signed [ACC_W-1:0] q_l,
  output logic                    dump_valid,
  output logic [CNT_W-1:0]        dump_count,
  output logic                    acc_ovf
);

  function automatic logic signed [4:0] carr_val(input logic [2:0] c);
    logic signed [4:0] m;
    m = $signed({3'b000, c[1:0]});
    carr_val = c[2] ? (5'sd0 - m) : m;
  endfunction

  function automatic logic signed [4:0] samp_val(input logic sgn, input logic mag);
    logic signed [4:0] m;
    m = mag ? 5'sd3 : 5'sd1;
    samp_val = sgn ? (5'sd0 - m) : m;
  endfunction

  function automatic logic signed [4:0] chip_mul(input logic chip, input logic signed [4:0] v);
    chip_mul = chip ? v : (5'sd0 - v);
  endfunction

  // Returns {saturation_event, sum}; the event bit can only be set in the saturating build.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [4:0] b);
`ifdef CORR_SAT_EN
    logic signed [ACC_W:0] wide;
    wide = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-4){b[4]}}, b});
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_add = wide[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_add = {1'b0, wide[ACC_W-1:0]};
    end
`else
    acc_add = {1'b0, a + $signed({{(ACC_W-5){b[4]}}, b})};
`endif
  endfunction

  logic                    sync1_r, sync2_r, sync3_r;
  logic                    dump_evt_s;
  logic signed [4:0]       mi_s, mq_s;
  logic signed [4:0]       prod_s [6];
  logic signed [4:0]       prod_r [6];
  logic                    v1_r;
  logic signed [ACC_W-1:0] acc_r  [6];
  logic signed [ACC_W-1:0] sum_s  [6];
  logic signed [ACC_W-1:0] dump_r [6];
  logic [ACC_W:0]          add_w;
  logic [5:0]              sat_s;
  logic                    dump_valid_r;
  logic [CNT_W-1:0]        dump_count_r;
  logic                    acc_ovf_r;

  // Dump strobe synchronizer; runs regardless of enable so a held strobe cannot re-fire on re-enable
  always_ff @(posedge mclk or posedge mclr) begin
    if (mclr) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= dump_strobe;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign dump_evt_s = sync2_r & ~sync3_r;

  // Carrier wipe-off and code chip signing; index order i_e, q_e, i_p, q_p, i_l, q_l
  always_comb begin
    mi_s      = samp_val(if_sign, if_mag) * carr_val(nco_carrier_cos);
    mq_s      = samp_val(if_sign, if_mag) * carr_val(nco_carrier_sin);
    prod_s[0] = chip_mul(code_early,  mi_s);
    prod_s[1] = chip_mul(code_early,  mq_s);
    prod_s[2] = chip_mul(code_prompt, mi_s);
    prod_s[3] = chip_mul(code_prompt, mq_s);
    prod_s[4] = chip_mul(code_late,   mi_s);
    prod_s[5] = chip_mul(code_late,   mq_s);
  end

  // Stage-1 product register
  always_ff @(posedge mclk or posedge mclr) begin
    if (mclr) begin
      v1_r <= 1'b0;
      for (int i = 0; i < 6; i++) prod_r[i] <= 5'sd0;
    end else if (!enable) begin
      v1_r <= 1'b0;
      for (int i = 0; i < 6; i++) prod_r[i] <= 5'sd0;
    end else begin
      v1_r <= if_valid;
      if (if_valid) begin
        for (int i = 0; i < 6; i++) prod_r[i] <= prod_s[i];
      end
    end
  end

  // Next accumulator value; also the dump value, so a product in flight at dump time is kept
  always_comb begin
    add_w = {(ACC_W+1){1'b0}};
    sat_s = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      add_w    = acc_add(acc_r[i], v1_r ? prod_r[i] : 5'sd0);
      sum_s[i] = $signed(add_w[ACC_W-1:0]);
      sat_s[i] = add_w[ACC_W];
    end
  end

  // Accumulators, dump latch, dump counter and sticky overflow
  always_ff @(posedge mclk or posedge mclr) begin
    if (mclr) begin
      for (int i = 0; i < 6; i++) begin
        acc_r[i]  <= {ACC_W{1'b0}};
        dump_r[i] <= {ACC_W{1'b0}};
      end
      dump_valid_r <= 1'b0;
      dump_count_r <= {CNT_W{1'b0}};
      acc_ovf_r    <= 1'b0;
    end else if (!enable) begin
      for (int i = 0; i < 6; i++) acc_r[i] <= {ACC_W{1'b0}};
      dump_valid_r <= 1'b0;
    end else if (dump_evt_s) begin
      for (int i = 0; i < 6; i++) begin
        dump_r[i] <= sum_s[i];
        acc_r[i]  <= {ACC_W{1'b0}};
      end
      dump_valid_r <= 1'b1;
      dump_count_r <= dump_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      acc_ovf_r    <= acc_ovf_r | (|sat_s);
    end else begin
      for (int i = 0; i < 6; i++) acc_r[i] <= sum_s[i];
      dump_valid_r <= 1'b0;
      acc_ovf_r    <= acc_ovf_r | (|sat_s);
    end
  end

  assign i_e        = dump_r[0];
  assign q_e        = dump_r[1];
  assign i_p        = dump_r[2];
  assign q_p        = dump_r[3];
  assign i_l        = dump_r[4];
  assign q_l        = dump_r[5];
  assign dump_valid = dump_valid_r;
  assign dump_count = dump_count_r;
  assign acc_ovf    = acc_ovf_r;

endmodule

// File: tb/tb_gps_corr_accum.sv
// Self-checking bench for gps_corr_accum: constant vector table, hand sequences and random epochs vs an integer model.
// A second instance with ACC_W = 8 exercises the overflow behaviour selected by CORR_SAT_EN.
module tb_gps_corr_accum;
  localparam int ACC_W = 20;
  localparam int CNT_W = 16;

  logic mclk = 1'b0;
  logic mclr, enable, if_valid, if_sign, if_mag;
  logic [2:0] cos_in, sin_in;
  logic code_early, code_prompt, code_late, dump_strobe;
  logic signed [ACC_W-1:0] i_e, q_e, i_p, q_p, i_l, q_l;
  logic dump_valid, acc_ovf;
  logic [CNT_W-1:0] dump_count;
  logic signed [7:0] i_e8, q_e8, i_p8, q_p8, i_l8, q_l8;
  logic dump_valid8, acc_ovf8;
  logic [CNT_W-1:0] dump_count8;

  gps_corr_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .mclk(mclk), .mclr(mclr), .enable(enable), .if_valid(if_valid), .if_sign(if_sign),
    .if_mag(if_mag), .nco_carrier_cos(cos_in), .nco_carrier_sin(sin_in),
    .code_early(code_early), .code_prompt(code_prompt), .code_late(code_late),
    .dump_strobe(dump_strobe), .i_e(i_e), .q_e(q_e), .i_p(i_p), .q_p(q_p), .i_l(i_l), .q_l(q_l),
    .dump_valid(dump_valid), .dump_count(dump_count), .acc_ovf(acc_ovf));

  gps_corr_accum #(.ACC_W(8), .CNT_W(CNT_W)) dut8 (
    .mclk(mclk), .mclr(mclr), .enable(enable), .if_valid(if_valid), .if_sign(if_sign),
    .if_mag(if_mag), .nco_carrier_cos(cos_in), .nco_carrier_sin(sin_in),
    .code_early(code_early), .code_prompt(code_prompt), .code_late(code_late),
    .dump_strobe(dump_strobe), .i_e(i_e8), .q_e(q_e8), .i_p(i_p8), .q_p(q_p8), .i_l(i_l8), .q_l(q_l8),
    .dump_valid(dump_valid8), .dump_count(dump_count8), .acc_ovf(acc_ovf8));

  always #5 mclk = ~mclk;

  typedef struct {
    bit sg; bit mg; logic [2:0] c; logic [2:0] s; bit e; bit p; bit l; int n;
    int x0; int x1; int x2; int x3; int x4; int x5;
  } vec_t;

  vec_t   tbl [4];
  int     checks = 0;
  int     failures = 0;
  int     model_cnt = 0;
  longint m_acc [6];
  longint last_exp [6];
`ifdef CORR_SAT_EN
  localparam longint OVF_IP = 127;
  localparam longint OVF_FLAG = 1;
`else
  localparam longint OVF_IP = -76;
  localparam longint OVF_FLAG = 0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  function automatic int pval(bit sgn, bit mag);
    return (mag ? 3 : 1) * (sgn ? -1 : 1);
  endfunction

  function automatic int cval(logic [2:0] c);
    return int'(c[1:0]) * (c[2] ? -1 : 1);
  endfunction

  // Reference: each accepted sample adds sample * carrier * chip (+1/-1) to its correlator sum
  task automatic model_sample();
    int car, chip;
    if (enable && if_valid) begin
      for (int k = 0; k < 6; k++) begin
        car = (k % 2 == 0) ? cval(cos_in) : cval(sin_in);
        case (k / 2)
          0:       chip = code_early  ? 1 : -1;
          1:       chip = code_prompt ? 1 : -1;
          default: chip = code_late   ? 1 : -1;
        endcase
        m_acc[k] += longint'(pval(if_sign, if_mag) * car * chip);
      end
    end
  endtask

  task automatic drive_cycle();
    model_sample();
    step();
  endtask

  task automatic model_clear();
    for (int k = 0; k < 6; k++) m_acc[k] = 0;
  endtask

  task automatic set_samp(bit v, bit sg, bit mg, logic [2:0] c, logic [2:0] s, bit e, bit p, bit l);
    if_valid = v; if_sign = sg; if_mag = mg; cos_in = c; sin_in = s;
    code_early = e; code_prompt = p; code_late = l;
  endtask

  // Raise the strobe for 'hold' sampled edges; count dump pulses and the edge index of the first
  task automatic do_dump(input int hold, output int pulses, output int first);
    dump_strobe = 1'b1;
    pulses = 0;
    first = -1;
    for (int c = 1; c <= hold + 6; c++) begin
      step();
      if (dump_valid) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == hold) dump_strobe = 1'b0;
    end
  endtask

  task automatic dump_chk(input string tag, input int hold);
    int pulses, first;
    do_dump(hold, pulses, first);
    model_cnt++;
    chk({tag, ".pulses"}, pulses, 1);
    chk({tag, ".latency"}, first, 3);
    chk({tag, ".count"}, dump_count, model_cnt % 65536);
  endtask

  task automatic cmp6(input string tag, input longint a0, input longint a1, input longint a2,
                      input longint a3, input longint a4, input longint a5);
    chk({tag, ".i_e"}, i_e, a0);
    chk({tag, ".q_e"}, q_e, a1);
    chk({tag, ".i_p"}, i_p, a2);
    chk({tag, ".q_p"}, q_p, a3);
    chk({tag, ".i_l"}, i_l, a4);
    chk({tag, ".q_l"}, q_l, a5);
    last_exp[0] = a0; last_exp[1] = a1; last_exp[2] = a2;
    last_exp[3] = a3; last_exp[4] = a4; last_exp[5] = a5;
  endtask

  initial begin
    int pulses, first, ncyc;
    tbl[0] = '{1'b0, 1'b0, 3'b010, 3'b001, 1'b0, 1'b1, 1'b1, 100, -200, -100, 200, 100, 200, 100};
    tbl[1] = '{1'b1, 1'b1, 3'b110, 3'b000, 1'b1, 1'b1, 1'b1, 10,  60, 0, 60, 0, 60, 0};
    tbl[2] = '{1'b0, 1'b1, 3'b011, 3'b111, 1'b1, 1'b0, 1'b1, 7,   63, -63, -63, 63, 63, -63};
    tbl[3] = '{1'b0, 1'b0, 3'b100, 3'b101, 1'b0, 1'b0, 1'b0, 5,   0, 5, 0, 5, 0, 5};

    mclr = 1'b1; enable = 1'b0; dump_strobe = 1'b0;
    set_samp(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    model_clear();
    step(); step();
    cmp6("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.count", dump_count, 0);
    chk("reset.valid", dump_valid, 0);
    chk("reset.ovf", acc_ovf, 0);
    mclr = 1'b0; enable = 1'b1;
    step(); step();

    // Constant-pattern vectors with hand-computed sums
    for (int t = 0; t < 4; t++) begin
      set_samp(1'b1, tbl[t].sg, tbl[t].mg, tbl[t].c, tbl[t].s, tbl[t].e, tbl[t].p, tbl[t].l);
      repeat (tbl[t].n) drive_cycle();
      if_valid = 1'b0;
      drive_cycle();
      dump_chk($sformatf("vec%0d", t), 3);
      cmp6($sformatf("vec%0d", t), tbl[t].x0, tbl[t].x1, tbl[t].x2, tbl[t].x3, tbl[t].x4, tbl[t].x5);
      model_clear();
    end

    // if_valid gaps, back-to-back dumps, strobe held high
    set_samp(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 50; c++) begin
      if_valid = (c % 2 == 0);
      drive_cycle();
    end
    if_valid = 1'b0;
    dump_chk("gaps", 1);
    chk("gaps.i_p", i_p, 25);
    dump_chk("empty", 1);
    chk("empty.i_p", i_p, 0);
    dump_chk("held", 20);
    model_clear();

    // Dump event coincides with a valid +9 stage-1 product
    dump_strobe = 1'b1;
    step();
    set_samp(1'b1, 1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 1'b1, 1'b0);
    step();
    if_valid = 1'b0;
    chk("coinc.early_valid", dump_valid, 0);
    step();
    model_cnt++;
    chk("coinc.valid", dump_valid, 1);
    chk("coinc.i_p", i_p, 9);
    chk("coinc.i_e", i_e, -9);
    dump_strobe = 1'b0;
    repeat (4) step();
    dump_chk("coinc_after", 1);
    cmp6("coinc_after", 0, 0, 0, 0, 0, 0);

    // Random epochs against the integer model
    for (int r = 0; r < 6; r++) begin
      ncyc = $urandom_range(20, 60);
      for (int c = 0; c < ncyc; c++) begin
        set_samp(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        drive_cycle();
      end
      if_valid = 1'b0;
      dump_chk($sformatf("rnd%0d", r), $urandom_range(1, 4));
      cmp6($sformatf("rnd%0d", r), m_acc[0], m_acc[1], m_acc[2], m_acc[3], m_acc[4], m_acc[5]);
      model_clear();
    end

    // Enable dropped in the dump-event cycle, then re-enabled while the strobe is still high
    set_samp(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
    repeat (4) drive_cycle();
    if_valid = 1'b0;
    dump_strobe = 1'b1;
    step(); step();
    enable = 1'b0;
    step();
    chk("endrop.valid", dump_valid, 0);
    step();
    enable = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (dump_valid) pulses++;
    end
    chk("endrop.stale_pulses", pulses, 0);
    chk("endrop.hold_i_p", i_p, last_exp[2]);
    chk("endrop.hold_count", dump_count, model_cnt % 65536);
    dump_strobe = 1'b0;
    repeat (3) step();
    model_clear();
    dump_chk("endrop_after", 1);
    cmp6("endrop_after", 0, 0, 0, 0, 0, 0);

    // Overflow on the 8-bit instance after a clean reset
    mclr = 1'b1;
    step();
    mclr = 1'b0;
    model_cnt = 0;
    model_clear();
    step();
    set_samp(1'b1, 1'b0, 1'b1, 3'b011, 3'b000, 1'b1, 1'b1, 1'b1);
    repeat (20) drive_cycle();
    if_valid = 1'b0;
    drive_cycle();
    dump_chk("ovf", 1);
    chk("ovf.main_i_p", i_p, 180);
    chk("ovf.main_flag", acc_ovf, 0);
    chk("ovf.i_p8", i_p8, OVF_IP);
    chk("ovf.i_e8", i_e8, OVF_IP);
    chk("ovf.flag8", acc_ovf8, OVF_FLAG);
    chk("ovf.count8", dump_count8, 1);
    dump_chk("ovf2", 1);
    chk("ovf2.i_p8", i_p8, 0);
    chk("ovf2.sticky8", acc_ovf8, OVF_FLAG);
    model_clear();

    // Asynchronous reset in the middle of accumulation
    set_samp(1'b1, 1'b0, 1'b1, 3'b011, 3'b000, 1'b1, 1'b1, 1'b1);
    repeat (5) drive_cycle();
    #2;
    mclr = 1'b1;
    #1;
    chk("mclr.i_p", i_p, 0);
    chk("mclr.count", dump_count, 0);
    chk("mclr.flag8", acc_ovf8, 0);
    chk("mclr.valid8", dump_valid8, 0);
    if_valid = 1'b0;
    step();
    mclr = 1'b0;
    model_cnt = 0;
    model_clear();
    step();
    dump_chk("mclr_after", 1);
    cmp6("mclr_after", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gps_corr_accum.md
Name: gps_corr_accum

Overview:
- Single-channel carrier/code correlator with accumulate-and-dump, directly downstream of the channel clock generator.
- Each valid IF sample is wiped off with the generator's 3-bit carrier sin/cos.
- The result is multiplied by early/prompt/late code chips and summed into six accumulators.
- On each 1 ms dump strobe (tr_accclr_clk1ms, produced on the code clock) the six sums are latched for the tracking loops and the accumulators restart.

Parameters:
- ACC_W, 20, accumulator and dump output width (signed two's complement), legal 8..32.
- CNT_W, 16, width of the dump epoch counter.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- mclr  in  1  reset; asynchronous, active-high.
- enable  in  1  channel enable.
- if_valid  in  1  qualifies if_sign/if_mag this cycle.
- if_sign  in  1  IF sample sign (1 = negative).
- if_mag  in  1  IF sample magnitude (0 -> 1, 1 -> 3).
- nco_carrier_cos  in  3  carrier cos: bit2 sign (1 = negative), bits1:0 unsigned magnitude 0..3.
- nco_carrier_sin  in  3  carrier sin, same format.
- code_early  in  1  early chip (1 -> +1, 0 -> -1).
- code_prompt  in  1  prompt chip.
- code_late  in  1  late chip.
- dump_strobe  in  1  asynchronous dump request (tr_accclr_clk1ms).
- i_e, q_e, i_p, q_p, i_l, q_l  out  ACC_W each  latched dump values.
- dump_valid  out  1  one-cycle pulse when dump outputs update.
- dump_count  out  CNT_W  number of dumps since reset, wraps.
- acc_ovf  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset: all accumulators, the six dump outputs, dump_count, dump_valid, acc_ovf and the sync flops go to 0.
- Sample value: s = (if_mag ? 3 : 1), negated if if_sign. Carrier values c, n = magnitude, negated if the sign bit is set. Magnitude 0 with sign 1 is treated as 0.
- Stage 1 (mix), registered when if_valid = 1:
  - mi = s*c, mq = s*n; 5-bit signed, range -9..+9.
  - Chip-signed products: pe_i = code_early ? mi : -mi, likewise for all six combinations (early/prompt/late x I/Q).
  - The stage-1 valid flag v1 follows if_valid.
- Stage 2 (accumulate): when v1 = 1, each accumulator adds its sign-extended stage-1 product.
- Sample latency: a sample captured at edge n appears in the accumulators at edge n+1.
- Dump synchronizer and edge detect:
  - dump_strobe passes through 2 flops (s1, s2), then a third (s3).
  - dump_evt = s2 & ~s3.
  - Strobe first sampled high at edge k gives dump outputs and dump_valid = 1 at edge k+2; dump_valid is low at edge k+3.
  - A strobe held high produces only one dump; a new dump requires the strobe to return low for 2 or more mclk cycles.
- Dump cycle (dump_evt = 1 and enable = 1):
  - Each output <= accumulator + (v1 ? product : 0), so no sample is lost.
  - Each accumulator <= 0.
  - dump_count increments, wrapping from all-ones to 0.
- enable = 0:
  - Accumulators and stage-1 registers are cleared every cycle.
  - dump_evt is ignored; dump_valid = 0.
  - Dump outputs and dump_count hold.
  - Sync flops keep running, so re-enabling during a high strobe does not fire a stale dump.
- enable falling in the same cycle as dump_evt: enable wins, no dump.
- mclr asserted mid-accumulation: immediate clear of all state, no partial dump emitted.
- Outputs are stable between dump_valid pulses.

Optional Feature:
- Macro: CORR_SAT_EN.
- Defined:
  - Each accumulator add saturates at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)).
  - Any saturation event sets acc_ovf, which is sticky until mclr.
  - The dump-cycle sum also saturates.
- Not defined:
  - Plain two's-complement wrap.
  - acc_ovf is tied to 0.

Test Plan:
- Basic accumulate and dump:
  - Stimulus: mclr pulse, enable = 1, 100 valid samples with if_sign = 0 and if_mag = 0, cos = 3'b010, sin = 3'b001, early = 0, prompt = 1, late = 1; then a dump_strobe pulse lasting 3 cycles.
  - Response: i_p = 200, q_p = 100, i_l = 200, q_l = 100, i_e = -200, q_e = -100; dump_valid one cycle, 2 edges after strobe sampled; dump_count = 1.
- Negative sample and negative carrier:
  - Stimulus: 10 samples with if_sign = 1, if_mag = 1, cos = 3'b110, prompt = 1, then dump.
  - Response: i_p = +60.
- if_valid gaps, back-to-back dumps, strobe held high:
  - Stimulus: alternate if_valid over 50 cycles (25 valid) with +1 x +1 x prompt; dump; immediately 0 samples; second dump; then hold strobe high for 20 cycles.
  - Response: first i_p = 25; second i_p = 0; only one dump during the 20-cycle high strobe; dump_count advances by exactly 1 per strobe.
- Dump coincident with valid sample:
  - Stimulus: dump_evt in the same cycle v1 = 1 carrying product +9.
  - Response: that product is included in the dump output; the accumulator restarts at 0.
- Enable and reset interactions:
  - Stimulus: drop enable in the dump_evt cycle.
  - Response: no dump_valid; outputs hold.
  - Stimulus: assert mclr mid-accumulation.
  - Response: all outputs and dump_count = 0 asynchronously.
- Overflow with ACC_W = 8:
  - Stimulus: feed +9 products for 20 samples.
  - Response with CORR_SAT_EN: i_p = 127, acc_ovf = 1 until reset.
  - Response without CORR_SAT_EN: i_p = 180 mod 256 = -76, acc_ovf = 0.
